// File: rtl/bicubic_patch_fetcher.sv
// -----------------------------------------------------------------------------
// bicubic_patch_fetcher
//
// Upstream feeder for the bicubic interpolation core. Walks the destination
// grid in raster order, tracking Q10.8 source coordinates with a DDA. For each
// output pixel it reads the clamped 4x4 source neighbourhood from the image ROM,
// builds the {1, f, f^2, f^3} phase-power vectors (Q0.8) for both axes and
// presents the patch to the core over a valid/ready handshake.
//
// Optional feature macro: BICUBIC_FETCH_REUSE_EN
//   When defined, a patch whose pixel lies in the same row and has the same
//   integer source column as the previous patch reuses the captured pixels:
//   no ROM reads, SETUP goes straight to PRESENT.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   start                 begin a job (sampled only in IDLE)
//   org_x, org_y          integer source origin of the first output pixel
//   step                  Q8.8 source increment per output pixel (both axes)
//   dst_w, dst_h          destination grid size
//   rom_rd, rom_addr      ROM read strobe / address (row*IMG_W+col)
//   rom_q                 ROM data, valid one cycle after rom_rd
//   patch_valid/ready     patch handshake
//   patch_pix             P[r][c] at bits [8*(4r+c)+:8], offsets -1..+2
//   patch_xpow/ypow       {f^3, f^2, f, 8'hFF}
//   busy                  high outside IDLE
//   done                  one-cycle pulse after the last patch is accepted
// -----------------------------------------------------------------------------
module bicubic_patch_fetcher #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        org_x,
    input  logic [7:0]        org_y,
    input  logic [15:0]       step,
    input  logic [7:0]        dst_w,
    input  logic [7:0]        dst_h,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic              patch_valid,
    input  logic              patch_ready,
    output logic [127:0]      patch_pix,
    output logic [31:0]       patch_xpow,
    output logic [31:0]       patch_ypow,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_FETCH, S_CAP, S_PRESENT, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    k_q, k_d;
    logic [7:0]    org_x_q, org_x_d;
    logic [15:0]   step_q, step_d;
    logic [7:0]    dst_w_q, dst_w_d, dst_h_q, dst_h_d;
    logic [7:0]    col_q, col_d, row_q, row_d;
    logic [17:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [127:0]  pix_q, pix_d;
    logic [31:0]   xpow_q, xpow_d, ypow_q, ypow_d;
    logic          reuse_q, reuse_d;

    // Rounded Q0.8 product: (a*b + 0.5 LSB) >> 8; never exceeds 8 bits.
    function automatic logic [7:0] mul_q8(input logic [7:0] a, input logic [7:0] b);
        return 8'((16'(a) * 16'(b) + 16'd128) >> 8);
    endfunction

    function automatic logic [31:0] pow_vec(input logic [7:0] f);
        logic [7:0] f2;
        f2 = mul_q8(f, f);
        return {mul_q8(f2, f), f2, f, 8'hFF};
    endfunction

    // Integer coordinate plus tap offset (-1..+2), clamped into [0, lim-1].
    // Evaluated signed and wide enough that i+2 cannot wrap.
    function automatic logic [9:0] clamp_tap(input logic [9:0] i, input logic [1:0] off,
                                             input int lim);
        logic signed [11:0] v;
        v = $signed({2'b00, i}) + $signed({10'd0, off}) - 12'sd1;
        if (v < 12'sd0)
            return 10'd0;
        else if (v > $signed(12'(lim - 1)))
            return 10'(lim - 1);
        else
            return v[9:0];
    endfunction

    logic [9:0] tap_row, tap_col;
    assign tap_row = clamp_tap(acc_y_q[17:8], k_q[3:2], IMG_H);
    assign tap_col = clamp_tap(acc_x_q[17:8], k_q[1:0], IMG_W);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        org_x_d     = org_x_q;
        step_d      = step_q;
        dst_w_d     = dst_w_q;
        dst_h_d     = dst_h_q;
        col_d       = col_q;
        row_d       = row_q;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        pix_d       = pix_q;
        xpow_d      = xpow_q;
        ypow_d      = ypow_q;
        reuse_d     = reuse_q;
        rom_rd      = 1'b0;
        rom_addr    = '0;
        patch_valid = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    org_x_d = org_x;
                    step_d  = step;
                    dst_w_d = dst_w;
                    dst_h_d = dst_h;
                    col_d   = 8'd0;
                    row_d   = 8'd0;
                    acc_x_d = {2'b00, org_x, 8'h00};
                    acc_y_d = {2'b00, org_y, 8'h00};
                    reuse_d = 1'b0;
                    state_d = (dst_w == 8'd0 || dst_h == 8'd0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                xpow_d  = pow_vec(acc_x_q[7:0]);
                ypow_d  = pow_vec(acc_y_q[7:0]);
                k_d     = 4'd0;
                state_d = reuse_q ? S_PRESENT : S_FETCH;
            end
            S_FETCH: begin
                rom_rd   = 1'b1;
                rom_addr = ADDR_W'(20'(tap_row) * 20'(IMG_W) + 20'(tap_col));
                // Data for the read issued in the previous cycle lands now.
                if (k_q != 4'd0)
                    pix_d[{k_q - 4'd1, 3'b000} +: 8] = rom_q;
                k_d = k_q + 4'd1;
                if (k_q == 4'd15)
                    state_d = S_CAP;
            end
            S_CAP: begin
                pix_d[127:120] = rom_q;
                state_d        = S_PRESENT;
            end
            S_PRESENT: begin
                patch_valid = 1'b1;
                if (patch_ready) begin
                    state_d = S_SETUP;
                    if (col_q == dst_w_q - 8'd1) begin
                        reuse_d = 1'b0;
                        if (row_q == dst_h_q - 8'd1) begin
                            state_d = S_DONE;
                        end else begin
                            col_d   = 8'd0;
                            row_d   = row_q + 8'd1;
                            acc_x_d = {2'b00, org_x_q, 8'h00};
                            acc_y_d = acc_y_q + 18'(step_q);
                        end
                    end else begin
                        col_d   = col_q + 8'd1;
                        acc_x_d = acc_x_q + 18'(step_q);
`ifdef BICUBIC_FETCH_REUSE_EN
                        reuse_d = (acc_x_d[17:8] == acc_x_q[17:8]);
`else
                        reuse_d = 1'b0;
`endif
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            org_x_q <= '0;
            step_q  <= '0;
            dst_w_q <= '0;
            dst_h_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            acc_x_q <= '0;
            acc_y_q <= '0;
            // NOTE: the patch register is reset too; it drives patch_pix
            // directly and must read zero after reset or an aborted job.
            pix_q   <= '0;
            xpow_q  <= '0;
            ypow_q  <= '0;
            reuse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            org_x_q <= org_x_d;
            step_q  <= step_d;
            dst_w_q <= dst_w_d;
            dst_h_q <= dst_h_d;
            col_q   <= col_d;
            row_q   <= row_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            pix_q   <= pix_d;
            xpow_q  <= xpow_d;
            ypow_q  <= ypow_d;
            reuse_q <= reuse_d;
        end
    end

    assign patch_pix  = pix_q;
    assign patch_xpow = xpow_q;
    assign patch_ypow = ypow_q;
    assign busy       = (state_q != S_IDLE);

endmodule
